// File: rtl/mem_ctrl_pkg.sv
// Shared encodings and state type for the data-RAM access controller.
package mem_ctrl_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StRelease,
    StResp
  } state_e;

  // Illegal size code or an access not naturally aligned to its size.
  function automatic logic req_bad(logic [1:0] size, logic [1:0] addr_lo);
    logic bad;
    unique case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Datapath request/response and RAM bus signals of the access controller.
interface mem_access_ctrl_if #(
  parameter int unsigned ADDR_W = 9
);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_err;
  logic [31:0]       rsp_rdata;
  logic              mem_enable;
  logic              mem_read_write;
  logic [1:0]        mem_data_length;
  logic [ADDR_W-1:0] mem_address;
  logic [31:0]       mem_data_in;
  logic [31:0]       mem_data_out;
  logic              mem_mfc;

  // Environment view: datapath plus RAM.
  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output mem_data_out, mem_mfc,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata,
    input  mem_enable, mem_read_write, mem_data_length, mem_address, mem_data_in
  );

  // Controller view.
  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  mem_data_out, mem_mfc,
    output req_ready, rsp_valid, rsp_err, rsp_rdata,
    output mem_enable, mem_read_write, mem_data_length, mem_address, mem_data_in
  );

endinterface

// File: rtl/mem_load_extend.sv
// Size/sign extension of right-justified RAM read data into a 32-bit result.
module mem_load_extend
  import mem_ctrl_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  output logic [31:0] data_o
);

  always_comb begin
    data_o = data_i;
    unique case (size_i)
      SZ_BYTE: data_o = {{24{signed_i & data_i[7]}}, data_i[7:0]};
      SZ_HALF: data_o = {{16{signed_i & data_i[15]}}, data_i[15:0]};
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-request load/store controller for the data RAM with MFC handshake,
// alignment checking and an MFC timeout.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned TIMEOUT = 16
) (
  input logic              clk,
  input logic              rst_n,
  mem_access_ctrl_if.slave bus
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  state_e            state_q;
  logic              write_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic              err_q;
  logic [CntW-1:0]   cnt_q;
  logic [31:0]       data_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [31:0]       rsp_rdata_q;
  logic              mem_enable_q;
  logic              mem_read_write_q;
  logic [1:0]        mem_data_length_q;
  logic [ADDR_W-1:0] mem_address_q;
  logic [31:0]       mem_data_in_q;
  logic [31:0]       ext_data;

  mem_load_extend u_load_extend (
    .data_i   (bus.mem_data_out),
    .size_i   (size_q),
    .signed_i (signed_q),
    .data_o   (ext_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= StIdle;
      write_q           <= 1'b0;
      size_q            <= SZ_BYTE;
      signed_q          <= 1'b0;
      err_q             <= 1'b0;
      cnt_q             <= '0;
      data_q            <= '0;
      rsp_valid_q       <= 1'b0;
      rsp_err_q         <= 1'b0;
      rsp_rdata_q       <= '0;
      mem_enable_q      <= 1'b0;
      mem_read_write_q  <= RW_READ;
      mem_data_length_q <= SZ_BYTE;
      mem_address_q     <= '0;
      mem_data_in_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            write_q  <= bus.req_write;
            size_q   <= bus.req_size;
            signed_q <= bus.req_signed;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            data_q   <= '0;
            if (req_bad(bus.req_size, bus.req_addr[1:0])) begin
              // Rejected requests never touch the RAM bus.
              state_q     <= StResp;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end else begin
              state_q           <= StAccess;
              mem_enable_q      <= 1'b1;
              mem_read_write_q  <= bus.req_write ? RW_WRITE : RW_READ;
              mem_data_length_q <= bus.req_size;
              mem_address_q     <= bus.req_addr;
              mem_data_in_q     <= bus.req_wdata;
            end
          end
        end
        StAccess: begin
          cnt_q <= cnt_q + 1'b1;
          if (bus.mem_mfc) begin
            if (!write_q) data_q <= ext_data;
            mem_enable_q <= 1'b0;
            state_q      <= StRelease;
          end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
            err_q        <= 1'b1;
            mem_enable_q <= 1'b0;
            state_q      <= StRelease;
          end
        end
        StRelease: begin
          if (!bus.mem_mfc) begin
            state_q     <= StResp;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= err_q;
            rsp_rdata_q <= err_q ? '0 : data_q;
          end
        end
        StResp: begin
          state_q     <= StIdle;
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= '0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready       = (state_q == StIdle);
  assign bus.rsp_valid       = rsp_valid_q;
  assign bus.rsp_err         = rsp_err_q;
  assign bus.rsp_rdata       = rsp_rdata_q;
  assign bus.mem_enable      = mem_enable_q;
  assign bus.mem_read_write  = mem_read_write_q;
  assign bus.mem_data_length = mem_data_length_q;
  assign bus.mem_address     = mem_address_q;
  assign bus.mem_data_in     = mem_data_in_q;

endmodule
